// File: rtl/disp_scan_if.sv
// Host/pin bundle for the display scan controller: the host drives enable and
// load data, the controller drives the decoder, anode and status lines.
interface disp_scan_if #(
  parameter int unsigned NDIG = 4
) ();
  logic              enable;
  logic              load;
  logic [4*NDIG-1:0] data;
  logic [NDIG-1:0]   dp_in;
  logic              load_ready;
  logic [3:0]        bcd;
  logic [NDIG-1:0]   an;
  logic              dp;
  logic              frame_done;

  modport master (
    output enable, load, data, dp_in,
    input  load_ready, bcd, an, dp, frame_done
  );

  modport slave (
    input  enable, load, data, dp_in,
    output load_ready, bcd, an, dp, frame_done
  );
endinterface

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed scan controller for NDIG common-anode 7-segment digits.
// New digit data lands in a shadow buffer and is committed to the displayed
// buffer only at a frame boundary (or while dark), so a frame never tears.
module disp_scan_ctrl #(
  parameter int unsigned NDIG   = 4,
  parameter int unsigned ON_CYC = 100000,
  parameter int unsigned GUARD  = 16,
  parameter int unsigned LZB    = 1
) (
  input logic        clk,
  input logic        rst,
  disp_scan_if.slave bus
);

  localparam int unsigned CntMax = (ON_CYC > GUARD) ? ON_CYC : GUARD;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned IdxW   = $clog2(NDIG);

  localparam logic [CntW-1:0] GuardLast = CntW'(GUARD - 1);
  localparam logic [CntW-1:0] OnLast    = CntW'(ON_CYC - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(NDIG - 1);

  typedef enum logic [1:0] {StOff, StGuard, StOn} state_e;

  state_e             st_q, st_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               fd_d;

  logic [4*NDIG-1:0]  shadow_q, shadow_d;
  logic [NDIG-1:0]    shadow_dp_q, shadow_dp_d;
  logic [4*NDIG-1:0]  active_q, active_d;
  logic [NDIG-1:0]    active_dp_q, active_dp_d;
  logic               pending_q, pending_d;
  logic               load_ready_q, load_ready_d;

  logic [NDIG-1:0]    an_q, an_d;
  logic               dp_q, dp_d;
  logic [3:0]         bcd_q, bcd_d;
  logic               fd_q;

  logic               commit;
  logic               accept;
  logic [NDIG-1:0]    nib_zero;
  logic [NDIG-1:0]    lead_zero;
  logic [NDIG-1:0]    blank_v;
  logic               blank_sel;

  // Scan state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= StOff;
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end

  // Guard/on schedule; dropping enable aborts to dark from any state.
  always_comb begin
    st_d  = st_q;
    idx_d = idx_q;
    cnt_d = cnt_q + CntW'(1);
    fd_d  = 1'b0;
    if (!bus.enable) begin
      st_d  = StOff;
      idx_d = '0;
      cnt_d = '0;
    end else begin
      case (st_q)
        StOff: begin
          st_d  = StGuard;
          idx_d = '0;
          cnt_d = '0;
        end
        StGuard: begin
          if (cnt_q == GuardLast) begin
            st_d  = StOn;
            cnt_d = '0;
          end
        end
        StOn: begin
          if (cnt_q == OnLast) begin
            st_d  = StGuard;
            cnt_d = '0;
            if (idx_q == IdxLast) begin
              idx_d = '0;
              fd_d  = 1'b1;
            end else begin
              idx_d = idx_q + IdxW'(1);
            end
          end
        end
        default: begin
          st_d  = StOff;
          idx_d = '0;
          cnt_d = '0;
        end
      endcase
    end
  end

  // Shadow/active buffering and the load handshake.
  always_comb begin
    commit      = pending_q & ((st_q == StOff) | fd_d);
    // pending_q implies load_ready_q=0, so accept and commit never coincide.
    accept      = bus.load & load_ready_q;
    shadow_d    = accept ? bus.data  : shadow_q;
    shadow_dp_d = accept ? bus.dp_in : shadow_dp_q;
    active_d    = commit ? shadow_q    : active_q;
    active_dp_d = commit ? shadow_dp_q : active_dp_q;
    pending_d   = accept ? 1'b1 : (commit ? 1'b0 : pending_q);
    // Stays low through the commit cycle, rises one cycle later.
    load_ready_d = ~pending_q & ~pending_d;
  end

  // Output decode from next-state values so registered pins line up with state.
  always_comb begin
    for (int i = 0; i < NDIG; i++) begin
      nib_zero[i] = (active_d[4*i +: 4] == 4'd0);
    end
    lead_zero[NDIG-1] = nib_zero[NDIG-1];
    for (int i = NDIG - 2; i >= 0; i--) begin
      lead_zero[i] = nib_zero[i] & lead_zero[i+1];
    end
    for (int i = 0; i < NDIG; i++) begin
      blank_v[i] = (active_d[4*i +: 4] > 4'd9) | ((LZB != 0) && (i != 0) && lead_zero[i]);
    end
    blank_sel = blank_v[idx_d];
    bcd_d     = active_d[{idx_d, 2'b00} +: 4];
    an_d      = '1;
    dp_d      = 1'b1;
    if (st_d == StOn && !blank_sel) begin
      an_d[idx_d] = 1'b0;
      dp_d        = ~active_dp_d[idx_d];
    end
  end

  // Buffers, handshake and registered pin drivers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q     <= '0;
      shadow_dp_q  <= '0;
      active_q     <= '0;
      active_dp_q  <= '0;
      pending_q    <= 1'b0;
      load_ready_q <= 1'b1;
      an_q         <= '1;
      dp_q         <= 1'b1;
      bcd_q        <= 4'd0;
      fd_q         <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      active_q     <= active_d;
      active_dp_q  <= active_dp_d;
      pending_q    <= pending_d;
      load_ready_q <= load_ready_d;
      an_q         <= an_d;
      dp_q         <= dp_d;
      bcd_q        <= bcd_d;
      fd_q         <= fd_d;
    end
  end

  assign bus.load_ready = load_ready_q;
  assign bus.an         = an_q;
  assign bus.dp         = dp_q;
  assign bus.bcd        = bcd_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Randomised bench for disp_scan_ctrl with a frame-position reference model.
module tb_disp_scan_ctrl;

  localparam int NDIG   = 4;
  localparam int ON_CYC = 4;
  localparam int GUARD  = 1;
  localparam int LZB    = 1;
  localparam int SLOT   = GUARD + ON_CYC;
  localparam int FRAME  = NDIG * SLOT;

  logic clk = 1'b0;
  logic rst = 1'b0;

  disp_scan_if #(.NDIG(NDIG)) bus ();

  disp_scan_ctrl #(
    .NDIG   (NDIG),
    .ON_CYC (ON_CYC),
    .GUARD  (GUARD),
    .LZB    (LZB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: scan position within the frame plus buffer contents.
  bit          m_run;
  int          m_pos;
  logic [15:0] m_act, m_sh;
  logic [3:0]  m_actdp, m_shdp;
  bit          m_pend, m_lr, m_commit_last, m_fd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_blank(input logic [15:0] w, input int i);
    logic [3:0] nib;
    nib = 4'((w >> (4 * i)) & 16'hF);
    if (nib > 4'd9) return 1'b1;
    if (LZB == 0 || i == 0) return 1'b0;
    return (w >> (4 * i)) == 16'd0;
  endfunction

  task automatic model_reset();
    m_run = 0; m_pos = 0;
    m_act = '0; m_sh = '0; m_actdp = '0; m_shdp = '0;
    m_pend = 0; m_lr = 1; m_commit_last = 0; m_fd = 0;
  endtask

  task automatic model_step();
    bit was_run, fd_next, commit, accept, new_lr;
    was_run = m_run;
    fd_next = m_run && bus.enable && (m_pos == FRAME - 1);
    if (!m_run) begin
      if (bus.enable) begin m_run = 1; m_pos = 0; end
    end else if (!bus.enable) begin
      m_run = 0; m_pos = 0;
    end else begin
      m_pos = (m_pos + 1) % FRAME;
    end
    commit = m_pend && (!was_run || fd_next);
    accept = bus.load && m_lr;
    new_lr = accept ? 1'b0 : (m_commit_last ? 1'b1 : m_lr);
    if (commit) begin m_act = m_sh; m_actdp = m_shdp; m_pend = 0; end
    if (accept) begin m_sh = bus.data; m_shdp = bus.dp_in; m_pend = 1; end
    m_commit_last = commit;
    m_lr = new_lr;
    m_fd = fd_next;
  endtask

  task automatic compare_all();
    bit         lit, blk;
    int         dig;
    logic [3:0] exp_an;
    logic       exp_dp;
    lit = m_run && ((m_pos % SLOT) >= GUARD);
    dig = m_run ? (m_pos / SLOT) : 0;
    blk = m_blank(m_act, dig);
    exp_an = 4'hF;
    exp_dp = 1'b1;
    if (lit && !blk) begin
      exp_an[dig] = 1'b0;
      exp_dp = ~m_actdp[dig];
    end
    check("an", 32'(bus.an), 32'(exp_an));
    check("dp", 32'(bus.dp), 32'(exp_dp));
    check("bcd", 32'(bus.bcd), 32'((m_act >> (4 * dig)) & 16'hF));
    check("frame_done", 32'(bus.frame_done), 32'(m_fd));
    check("load_ready", 32'(bus.load_ready), 32'(m_lr));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    bus.load = 1'b1; bus.data = d; bus.dp_in = p;
    step();
    bus.load = 1'b0;
  endtask

  // Advance (bounded) until the model is lit on digit d.
  task automatic run_to_lit(input int d);
    for (int k = 0; k < 2 * FRAME; k++) begin
      if (m_run && (m_pos / SLOT) == d && (m_pos % SLOT) >= GUARD) break;
      step();
    end
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, "_an"}, 32'(bus.an), 32'hF);
    check({tag, "_dp"}, 32'(bus.dp), 32'd1);
    check({tag, "_bcd"}, 32'(bus.bcd), 32'd0);
    check({tag, "_ld_rdy"}, 32'(bus.load_ready), 32'd1);
    check({tag, "_fd"}, 32'(bus.frame_done), 32'd0);
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    case ($urandom_range(0, 3))
      0: w = w;
      1: w = w >> (4 * $urandom_range(1, 3));
      2: begin
        for (int i = 0; i < NDIG; i++) w[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      default: w = 16'd0;
    endcase
    return w;
  endfunction

  initial begin
    bus.enable = 1'b0; bus.load = 1'b0; bus.data = '0; bus.dp_in = '0;
    model_reset();
    #1 rst = 1'b1;
    #1 check_reset_pins("por");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Basic scan of 1234.
    run(2);
    do_load(16'h1234, 4'b0000);
    run(2);
    bus.enable = 1'b1;
    run(2 * FRAME + 3);

    // Tear-free update while digit 1 is lit.
    run_to_lit(1);
    do_load(16'h5678, 4'b0000);
    run(2 * FRAME);

    // Decimal point and blanking patterns.
    do_load(16'h1234, 4'b0010); run(2 * FRAME);
    do_load(16'h12A4, 4'b0010); run(2 * FRAME);
    do_load(16'h0040, 4'b0000); run(2 * FRAME);
    do_load(16'h0000, 4'b0001); run(2 * FRAME);

    // Abort during digit 2 with a load pending, then restart.
    do_load(16'h1234, 4'b0000); run(2 * FRAME);
    run_to_lit(1);
    do_load(16'h9876, 4'b0100);
    run_to_lit(2);
    run(1);
    bus.enable = 1'b0;
    run(4);
    bus.enable = 1'b1;
    run(2 * FRAME);

    // Asynchronous reset in the middle of an ON window.
    run_to_lit(2);
    rst = 1'b1;
    #1 check_reset_pins("mid_rst");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    run(FRAME);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      bus.load = ($urandom_range(0, 9) == 0);
      if (bus.load) begin
        bus.data  = rand_word();
        bus.dp_in = 4'($urandom);
      end
      if ($urandom_range(0, 149) == 0) bus.enable = ~bus.enable;
      else if (!bus.enable && $urandom_range(0, 7) == 0) bus.enable = 1'b1;
      step();
    end
    bus.load = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Time-multiplexing controller that shares the single combinational BCD-to-7-segment decoder among NDIG common-anode digits. Holds a double-buffered digit word, steps a digit pointer through a guard/on schedule, drives the decoder's 4-bit BCD input and the active-low anode and decimal-point lines, and commits new display data only at frame boundaries so the display never tears. Sits between the register/host logic and the board's segment and anode pins.

## Interface
- NDIG, 4: number of digits, 2..8; digit 0 is least significant.
- ON_CYC, 100000: clock cycles each digit is lit, ≥1.
- GUARD, 16: cycles all anodes are off between digits (anti-ghosting), ≥1.
- LZB, 1: 1 enables leading-zero blanking.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  1 = scan, 0 = display dark.
- load  in  1  write strobe for data/dp_in; accepted only when load_ready=1.
- data  in  4*NDIG  BCD digits, nibble i = digit i.
- dp_in  in  NDIG  decimal point per digit, 1 = lit.
- load_ready  out  1  1 = shadow buffer free.
- bcd  out  4  to decoder input, bit 0 = LSB (decoder input A).
- an  out  NDIG  anode enables, active-low.
- dp  out  1  decimal point, active-low.
- frame_done  out  1  one-cycle pulse at end of each full scan.

## Operation
- Registers: shadow (data+dp, written by load), active (displayed), pending flag, digit index idx, cycle counter cnt (width clog2(max(ON_CYC,GUARD))).
- Load: load & load_ready → shadow captured, pending=1, load_ready=0 next cycle. load while load_ready=0 is ignored (no overwrite).
- Commit: if pending, active←shadow, pending←0 when (a) frame_done is asserted, or (b) state is OFF. load_ready returns to 1 the cycle after commit.
- States:
  - OFF: an all 1, dp=1, idx=0, cnt=0. enable=1 → GUARD.
  - GUARD: an all 1, dp=1, bcd=active nibble idx. After GUARD cycles → ON, cnt=0.
  - ON: an[idx]=0 unless digit blanked; dp=~dp_active[idx] (forced 1 if blanked). After ON_CYC cycles: idx<NDIG-1 → idx+1, GUARD; idx=NDIG-1 → idx=0, frame_done pulse, GUARD.
  - Any state, enable=0 → OFF next cycle (mid-digit abort, no frame_done).
- Blanking: digit blanked if nibble >9, or LZB=1 and it and every more-significant nibble are 0 and idx≠0. Digit 0 is never blanked by LZB. Blanked digit still occupies its ON slot (constant refresh rate).
- Frame period = NDIG*(GUARD+ON_CYC) cycles.

## Timing
- Reset values: an all 1, dp=1, bcd=0, frame_done=0, load_ready=1, idx=0, cnt=0, state OFF, shadow/active/pending all 0.
- All outputs registered; bcd is stable during the whole GUARD preceding its digit's ON window.
- Reset asserted mid-frame: all outputs return to reset values asynchronously; shadow content lost.
- enable rising: first GUARD cycle is the cycle after enable is sampled high; an[0] falls GUARD+1 cycles after that edge.
- load in the same cycle as commit: load_ready=0 that cycle, so load is ignored.
- Commit at frame_done takes effect for digit 0 of the next frame; no digit shows mixed old/new data.
- cnt counts 0..limit-1 and wraps to 0 on every state transition.

## Test plan
- Reset: assert rst mid-ON with NDIG=4, ON_CYC=4, GUARD=1 → an=4'b1111, dp=1, bcd=0, load_ready=1 immediately.
- Basic scan: load data=16'h1234, enable=1 → an sequence 1110,1101,1011,0111 each 4 cycles separated by one 1111 cycle; bcd=4,3,2,1; frame_done once every 20 cycles.
- Tear-free commit: while enabled with 16'h1234, load 16'h5678 during digit 1 → rest of frame shows 1234, load_ready=0 until one cycle after frame_done, next frame shows 8,7,6,5.
- Leading zeros: LZB=1, data=16'h0040 → digits 3 and 2 blanked (an stay 1), digit 1 shows 4, digit 0 shows 0; data=16'h0000 → only digit 0 lit.
- Invalid/dp: data=16'h12A4, dp_in=4'b0010 → digit 1 blanked (nibble A), dp=0 never asserted since digit 1 blank; with 16'h1234 dp=0 only during an=1101.
- Enable abort: drop enable during digit 2 ON → next cycle an=1111, idx=0, no frame_done; pending load commits next cycle in OFF; re-enable restarts at digit 0.
